// File: rtl/rf_writeback_arb.sv
// rtl/rf_writeback_arb.sv - register file writeback arbiter with long-latency result FIFO and busy scoreboard
module rf_writeback_arb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_we,
  input  logic [4:0]                 pipe_rd,
  input  logic [XLEN-1:0]            pipe_wd,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_rd,
  output logic                       issue_ready,
  input  logic                       lu_valid,
  input  logic [4:0]                 lu_rd,
  input  logic [XLEN-1:0]            lu_wd,
  output logic                       lu_ready,
  input  logic [4:0]                 q1_addr,
  input  logic [4:0]                 q2_addr,
  output logic                       q1_busy,
  output logic                       q2_busy,
  output logic                       rf_we,
  output logic [4:0]                 rf_a3,
  output logic [XLEN-1:0]            rf_wd3,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      fifo_rd [DEPTH];
  logic [XLEN-1:0] fifo_wd [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [31:0]     busy;
  logic [31:0]     busy_next;
  logic            from_fifo;
  logic            pipe_hit;
  logic            push;
  logic            pop;

  always_comb begin
    lu_ready    = (fifo_count != CW'(DEPTH));
    issue_ready = !busy[issue_rd];
    q1_busy     = busy[q1_addr];
    q2_busy     = busy[q2_addr];
    pipe_hit    = pipe_we && (pipe_rd != 5'd0);
    // Zero-destination results are acknowledged but never stored.
    push        = lu_valid && lu_ready && (lu_rd != 5'd0);
    // Uses the registered count, so a fresh push cannot bypass to the write port.
    pop         = !pipe_hit && (fifo_count != '0);
  end

  // Clear lands on the edge where the register file captures the FIFO-sourced write.
  always_comb begin
    busy_next = busy;
    if (rf_we && from_fifo) begin
      busy_next[rf_a3] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr] <= lu_rd;
      fifo_wd[wr_ptr] <= lu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_a3      <= 5'd0;
      rf_wd3     <= '0;
      from_fifo  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      busy       <= '0;
    end else begin
      busy <= busy_next;
      if (pipe_hit) begin
        rf_we     <= 1'b1;
        rf_a3     <= pipe_rd;
        rf_wd3    <= pipe_wd;
        from_fifo <= 1'b0;
      end else if (pop) begin
        rf_we     <= 1'b1;
        rf_a3     <= fifo_rd[rd_ptr];
        rf_wd3    <= fifo_wd[rd_ptr];
        from_fifo <= 1'b1;
      end else begin
        rf_we     <= 1'b0;
        from_fifo <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_writeback_arb.sv
// tb/tb_rf_writeback_arb.sv - self-checking bench for rf_writeback_arb
module tb_rf_writeback_arb;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pipe_we = 1'b0;
  logic [4:0]      pipe_rd = '0;
  logic [XLEN-1:0] pipe_wd = '0;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_rd = '0;
  logic            issue_ready;
  logic            lu_valid = 1'b0;
  logic [4:0]      lu_rd = '0;
  logic [XLEN-1:0] lu_wd = '0;
  logic            lu_ready;
  logic [4:0]      q1_addr = '0;
  logic [4:0]      q2_addr = '0;
  logic            q1_busy;
  logic            q2_busy;
  logic            rf_we;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd3;
  logic [1:0]      fifo_count;

  int total = 0;
  int bad   = 0;

  rf_writeback_arb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending results and a per-register busy table.
  logic [36:0] mq[$];
  bit          m_busy[32];
  logic        m_we  = 1'b0;
  logic [4:0]  m_a3  = '0;
  logic [31:0] m_wd  = '0;
  logic        m_src = 1'b0;

  task automatic model_edge();
    bit lr;
    bit ir;
    logic [36:0] head;
    if (rst) begin
      mq.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_a3 = '0; m_wd = '0; m_src = 1'b0;
      return;
    end
    lr = (mq.size() != DEPTH);
    ir = (issue_rd == 0) || !m_busy[issue_rd];
    if (m_we && m_src) m_busy[m_a3] = 1'b0;
    if (issue_valid && ir && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (pipe_we && pipe_rd != 0) begin
      m_we = 1'b1; m_a3 = pipe_rd; m_wd = pipe_wd; m_src = 1'b0;
    end else if (mq.size() > 0) begin
      head = mq.pop_front();
      m_we = 1'b1; m_a3 = head[36:32]; m_wd = head[31:0]; m_src = 1'b1;
    end else begin
      m_we = 1'b0; m_src = 1'b0;
    end
    if (lu_valid && lr && lu_rd != 0) mq.push_back({lu_rd, lu_wd});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0b want=0", rf_we); end
    total++; if (fifo_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL reset_lu_ready got=%0b want=1", lu_ready); end
    total++; if (rf_a3 !== 5'd0 || rf_wd3 !== 32'd0) begin bad++; $display("FAIL reset_rf_addr_data got=%0d/%0h want=0/0", rf_a3, rf_wd3); end
    for (int r = 0; r < 32; r += 5) begin
      issue_rd = 5'(r); q1_addr = 5'(r); q2_addr = 5'(31 - r);
      #1;
      total++;
      if (issue_ready !== 1'b1 || q1_busy !== 1'b0 || q2_busy !== 1'b0) begin
        bad++; $display("FAIL reset_idle_r%0d got=%0b%0b%0b want=100", r, issue_ready, q1_busy, q2_busy);
      end
    end
  endtask

  task automatic test_pipe();
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hDEADBEEF;
    tick();
    pipe_rd = 5'd0; pipe_wd = 32'h11111111;
    total++;
    if (rf_we !== 1'b1 || rf_a3 !== 5'd5 || rf_wd3 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL pipe_write got=%0b/%0d/%0h want=1/5/deadbeef", rf_we, rf_a3, rf_wd3);
    end
    tick();
    pipe_we = 1'b0;
    total++;
    if (rf_we !== 1'b0 || rf_a3 !== 5'd5 || rf_wd3 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL pipe_rd0_dropped got=%0b/%0d/%0h want=0/5/deadbeef", rf_we, rf_a3, rf_wd3);
    end
  endtask

  task automatic test_long_latency();
    issue_valid = 1'b1; issue_rd = 5'd7; q1_addr = 5'd7;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL ll_issue_ready_pre got=%0b want=1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    #1;
    total++; if (q1_busy !== 1'b1) begin bad++; $display("FAIL ll_busy_set got=%0b want=1", q1_busy); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL ll_issue_blocked got=%0b want=0", issue_ready); end
    lu_valid = 1'b1; lu_rd = 5'd7; lu_wd = 32'h12345678;
    tick();
    lu_valid = 1'b0;
    total++;
    if (fifo_count !== 2'd1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL ll_pushed got=%0d/%0b want=1/0", fifo_count, rf_we);
    end
    tick();
    total++;
    if (rf_we !== 1'b1 || rf_a3 !== 5'd7 || rf_wd3 !== 32'h12345678 || fifo_count !== 2'd0) begin
      bad++; $display("FAIL ll_emit got=%0b/%0d/%0h/%0d want=1/7/12345678/0", rf_we, rf_a3, rf_wd3, fifo_count);
    end
    total++; if (q1_busy !== 1'b1) begin bad++; $display("FAIL ll_busy_until_commit got=%0b want=1", q1_busy); end
    tick();
    total++;
    if (q1_busy !== 1'b0 || rf_we !== 1'b0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL ll_busy_cleared got=%0b/%0b/%0b want=0/0/1", q1_busy, rf_we, issue_ready);
    end
  endtask

  task automatic test_backpressure();
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h33;
    lu_valid = 1'b1; lu_rd = 5'd8; lu_wd = 32'h88;
    tick();
    lu_rd = 5'd9; lu_wd = 32'h99;
    tick();
    lu_rd = 5'd10; lu_wd = 32'hAA;
    total++;
    if (fifo_count !== 2'd2 || lu_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full got=%0d/%0b want=2/0", fifo_count, lu_ready);
    end
    tick();
    total++;
    if (fifo_count !== 2'd2 || rf_a3 !== 5'd3 || rf_we !== 1'b1) begin
      bad++; $display("FAIL bp_stall got=%0d/%0d want=2/3", fifo_count, rf_a3);
    end
    pipe_we = 1'b0; lu_valid = 1'b0;
    tick();
    total++;
    if (rf_we !== 1'b1 || rf_a3 !== 5'd8 || rf_wd3 !== 32'h88) begin
      bad++; $display("FAIL bp_drain_first got=%0d/%0h want=8/88", rf_a3, rf_wd3);
    end
    tick();
    total++;
    if (rf_we !== 1'b1 || rf_a3 !== 5'd9 || rf_wd3 !== 32'h99) begin
      bad++; $display("FAIL bp_drain_second got=%0d/%0h want=9/99", rf_a3, rf_wd3);
    end
    tick();
    total++;
    if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
      bad++; $display("FAIL bp_empty got=%0b/%0d want=0/0", rf_we, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    lu_valid = 1'b1; lu_rd = 5'd11; lu_wd = 32'hA0;
    tick();
    for (int i = 0; i < 6; i++) begin
      lu_rd = 5'(12 + i); lu_wd = 32'(32'hB0 + i);
      tick();
      total++;
      if (fifo_count !== 2'd1 || rf_we !== 1'b1 || rf_a3 !== 5'(11 + i) ||
          rf_wd3 !== ((i == 0) ? 32'hA0 : 32'(32'hB0 + i - 1))) begin
        bad++; $display("FAIL b2b_wrap_%0d got=%0d/%0d/%0h", i, fifo_count, rf_a3, rf_wd3);
      end
    end
    lu_rd = 5'd0; lu_wd = 32'hFF;
    tick();
    lu_valid = 1'b0;
    total++;
    if (fifo_count !== 2'd0 || rf_wd3 !== 32'hB5 || rf_a3 !== 5'd17) begin
      bad++; $display("FAIL b2b_zero_rd got=%0d/%0d/%0h want=0/17/b5", fifo_count, rf_a3, rf_wd3);
    end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL b2b_zero_rd_emit got=%0b want=0", rf_we); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd8;
    tick();
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    pipe_we = 1'b1; pipe_rd = 5'd3;
    lu_valid = 1'b1; lu_rd = 5'd8; lu_wd = 32'h8;
    tick();
    lu_rd = 5'd9; lu_wd = 32'h9;
    tick();
    lu_valid = 1'b0; q1_addr = 5'd8; q2_addr = 5'd9;
    #1;
    total++;
    if (fifo_count !== 2'd2 || q1_busy !== 1'b1 || q2_busy !== 1'b1) begin
      bad++; $display("FAIL rm_pre got=%0d/%0b/%0b want=2/1/1", fifo_count, q1_busy, q2_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; pipe_we = 1'b0; issue_rd = 5'd8;
    #1;
    total++;
    if (fifo_count !== 2'd0 || rf_we !== 1'b0 || q1_busy !== 1'b0 || q2_busy !== 1'b0 || issue_ready !== 1'b1) begin
      bad++; $display("FAIL rm_post got=%0d/%0b/%0b/%0b/%0b want=0/0/0/0/1", fifo_count, rf_we, q1_busy, q2_busy, issue_ready);
    end
  endtask

  task automatic test_random();
    bit exp_ir;
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      pipe_we     = ($urandom_range(0, 9) < 4);
      pipe_rd     = 5'($urandom_range(0, 7));
      pipe_wd     = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      lu_valid    = ($urandom_range(0, 1) == 0);
      lu_rd       = 5'($urandom_range(0, 7));
      lu_wd       = $urandom;
      q1_addr     = 5'($urandom_range(0, 7));
      q2_addr     = 5'($urandom_range(0, 7));
      #1;
      exp_ir = (issue_rd == 0) || !m_busy[issue_rd];
      total++;
      if (lu_ready !== (mq.size() != DEPTH) || issue_ready !== exp_ir ||
          q1_busy !== m_busy[q1_addr] || q2_busy !== m_busy[q2_addr]) begin
        bad++; $display("FAIL rnd_comb_%0d got=%0b%0b%0b%0b want=%0b%0b%0b%0b", c,
                        lu_ready, issue_ready, q1_busy, q2_busy,
                        (mq.size() != DEPTH), exp_ir, m_busy[q1_addr], m_busy[q2_addr]);
      end
      tick();
      total++;
      if (rf_we !== m_we || rf_a3 !== m_a3 || rf_wd3 !== m_wd || fifo_count !== 2'(mq.size())) begin
        bad++; $display("FAIL rnd_reg_%0d got=%0b/%0d/%0h/%0d want=%0b/%0d/%0h/%0d", c,
                        rf_we, rf_a3, rf_wd3, fifo_count, m_we, m_a3, m_wd, mq.size());
      end
      total++;
      if (rf_we === 1'b1 && rf_a3 === 5'd0) begin
        bad++; $display("FAIL rnd_zero_write_%0d got=a3 0 want=nonzero", c);
      end
    end
    rst = 1'b0; pipe_we = 1'b0; issue_valid = 1'b0; lu_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_long_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
